data_ram_arbiter: RTL
=====================

Name: data_ram_arbiter

Overview:
- Shares the single-port data_ram between the CPU data port and a DMA/loader master.
- Sits between openmips (ram_* outputs, stall request input) and data_ram.
- CPU has priority every cycle; DMA uses idle cycles.
- A starvation counter forces a one-cycle CPU stall so the DMA always makes progress.

Parameters:
- STARVE_LIMIT, 8: consecutive denied DMA cycles before a forced grant; 0 disables forcing.
- CNT_W, 4: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- cpu_ce_i  in  1  CPU data access request.
- cpu_we_i  in  1  CPU write enable.
- cpu_addr_i  in  32  CPU byte address.
- cpu_sel_i  in  4  CPU byte selects.
- cpu_data_i  in  32  CPU write data.
- cpu_data_o  out  32  read data to CPU.
- cpu_stall_o  out  1  stall request to the CPU pipeline.
- dma_req_i  in  1  DMA word request; held until ack.
- dma_we_i  in  1  DMA write enable.
- dma_addr_i  in  32  DMA byte address.
- dma_sel_i  in  4  DMA byte selects.
- dma_wdata_i  in  32  DMA write data.
- dma_ack_o  out  1  one-cycle pulse: DMA word completed.
- dma_rdata_o  out  32  registered DMA read data, valid with dma_ack_o.
- ram_ce_o, ram_we_o  out  1 each  to data_ram.
- ram_addr_o  out  32  to data_ram.
- ram_sel_o  out  4  to data_ram.
- ram_data_o  out  32  to data_ram.
- ram_data_i  in  32  combinational read data from data_ram.
- owner_o  out  2  current-cycle owner: 00 none, 01 CPU, 10 DMA.

Behaviour:
- States: NORMAL and FORCE; state register updates on posedge clk.
- Reset (rst=0, async) clears everything:
  - state=NORMAL, wait_cnt=0.
  - dma_ack_o=0, dma_rdata_o=0.
  - Combinational outputs resolve to no owner: ram_ce_o=0, ram_we_o=0, owner_o=00, cpu_stall_o=0.
  - Reset mid-transfer drops the pending DMA word with no ack; the master must re-request.
- DMA eligibility: eligible = dma_req_i && !dma_ack_o. The ack cycle is ignored so the master can change or drop its request; maximum DMA rate is one word per 2 cycles.
- Ownership (combinational from state and inputs):
  - FORCE: DMA owns; cpu_stall_o=1.
  - NORMAL with cpu_ce_i=1: CPU owns.
  - NORMAL with cpu_ce_i=0 and eligible: DMA owns.
  - Otherwise: none.
- Muxing:
  - ram_* outputs come from the owner's inputs. When there is no owner, ram_ce_o=0 and ram_we_o=0; addr, sel and data outputs are 0.
  - cpu_data_o = ram_data_i in all cases; it is meaningful only when CPU owns.
- DMA completion: in any cycle where DMA owns, the next edge sets dma_ack_o=1 and dma_rdata_o=ram_data_i (captured for writes too). Otherwise dma_ack_o goes to 0; dma_rdata_o holds.
- Starvation counter in NORMAL:
  - eligible && CPU owns: wait_cnt+1, saturating.
  - DMA granted or !dma_req_i: wait_cnt=0.
  - STARVE_LIMIT != 0, eligible, CPU owns, and wait_cnt == STARVE_LIMIT-1: next state=FORCE.
- FORCE lasts exactly one cycle:
  - DMA access is performed regardless of cpu_ce_i; CPU write suppressed (ram_we_o follows dma_we_i).
  - Next state=NORMAL, wait_cnt=0.
  - The CPU holds its MEM-stage outputs while stalled and reissues the access next cycle.
- If dma_req_i drops while in FORCE, the cycle still completes with owner none (not DMA), no ack, and cpu_stall_o=1.
- Writes commit at the data_ram edge in the owning cycle only; there is never a double commit.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined — adds outputs:
  - conflict_cnt_o (16): increments each cycle eligible && CPU owns.
  - force_cnt_o (16): increments on each FORCE cycle.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined — these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- DMA only, cpu_ce_i=0; DMA write 0x1234_5678 to 0x10, then read 0x10 -> ack one cycle after each grant; dma_rdata_o=0x1234_5678; owner_o=10 in each grant cycle.
- CPU only, CPU write 0xAABBCCDD to 0x20 with sel=4'b1111, then read -> cpu_data_o=0xAABBCCDD; dma_ack_o stays 0; cpu_stall_o stays 0.
- STARVE_LIMIT=8; cpu_ce_i=1 continuously with dma_req_i held from cycle 0 -> cycles 0–7 CPU owns; cycle 8 FORCE with cpu_stall_o=1 and owner_o=10; ack in cycle 9; wait_cnt=0.
- STARVE_LIMIT=0, same stimulus for 100 cycles -> no FORCE, no ack, cpu_stall_o never asserted.
- DMA granted in cycle 4, rst pulled low in cycle 5 before the edge -> dma_ack_o=0 immediately, state=NORMAL, RAM holds the cycle-4 write (committed before reset).
- With ARB_PERF_CNT_EN, run the starvation scenario twice -> conflict_cnt_o=16, force_cnt_o=2.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// Arbiter sharing the single-port data_ram between the CPU data port (priority) and a DMA master.
// Define ARB_PERF_CNT_EN to add saturating conflict/force performance counters.
module data_ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        cpu_stall_o,

    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [31:0] dma_addr_i,
    input  logic [3:0]  dma_sel_i,
    input  logic [31:0] dma_wdata_i,
    output logic        dma_ack_o,
    output logic [31:0] dma_rdata_o,

    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,

    output logic [1:0]  owner_o
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0] conflict_cnt_o,
    output logic [15:0] force_cnt_o
`endif
);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA  = 2'b10
    } owner_e;

    localparam logic             FORCE_EN = (STARVE_LIMIT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] FORCE_AT = (STARVE_LIMIT == 0) ? '0 : CNT_W'(STARVE_LIMIT - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              dma_ack_q;
    logic [31:0]       dma_rdata_q;

    owner_e            owner;
    logic              eligible;
    logic              conflict;

    // The ack cycle is not eligible, so the master may retarget or drop its request then.
    assign eligible = dma_req_i && !dma_ack_q;
    assign conflict = eligible && (owner == OWN_CPU);

    always_comb begin
        // NOTE: every path assigns owner because of this default, so no latch is inferred.
        owner = OWN_NONE;
        if (!rst) begin
            owner = OWN_NONE;
        end else if (state_q == ST_FORCE) begin
            owner = eligible ? OWN_DMA : OWN_NONE;
        end else if (cpu_ce_i) begin
            owner = OWN_CPU;
        end else if (eligible) begin
            owner = OWN_DMA;
        end
    end

    always_comb begin
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_sel_o  = '0;
        ram_data_o = '0;
        unique case (owner)
            OWN_CPU: begin
                ram_ce_o   = 1'b1;
                ram_we_o   = cpu_we_i;
                ram_addr_o = cpu_addr_i;
                ram_sel_o  = cpu_sel_i;
                ram_data_o = cpu_data_i;
            end
            OWN_DMA: begin
                ram_ce_o   = 1'b1;
                ram_we_o   = dma_we_i;
                ram_addr_o = dma_addr_i;
                ram_sel_o  = dma_sel_i;
                ram_data_o = dma_wdata_i;
            end
            default: ;
        endcase
    end

    assign owner_o     = owner;
    assign cpu_data_o  = ram_data_i;
    assign cpu_stall_o = (state_q == ST_FORCE);
    assign dma_ack_o   = dma_ack_q;
    assign dma_rdata_o = dma_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state_q     <= ST_NORMAL;
            wait_cnt_q  <= '0;
            dma_ack_q   <= 1'b0;
            dma_rdata_q <= '0;
        end else begin
            dma_ack_q <= (owner == OWN_DMA);
            if (owner == OWN_DMA) begin
                dma_rdata_q <= ram_data_i;
            end

            unique case (state_q)
                ST_FORCE: begin
                    state_q    <= ST_NORMAL;
                    wait_cnt_q <= '0;
                end
                default: begin
                    if (conflict) begin
                        if (wait_cnt_q != CNT_MAX) begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                        end
                        if (FORCE_EN && (wait_cnt_q == FORCE_AT)) begin
                            state_q <= ST_FORCE;
                        end
                    end else if ((owner == OWN_DMA) || !dma_req_i) begin
                        wait_cnt_q <= '0;
                    end
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [15:0] conflict_cnt_q;
    logic [15:0] force_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt_q <= '0;
            force_cnt_q    <= '0;
        end else begin
            if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
            if ((state_q == ST_FORCE) && (force_cnt_q != 16'hFFFF)) begin
                force_cnt_q <= force_cnt_q + 16'd1;
            end
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
    assign force_cnt_o    = force_cnt_q;
`endif

endmodule
